// File: rtl/masked_gf16_mult_compress.sv
// Re-masks the nine 3-share GF(16) partial products with fresh r, registers them, then compresses to 3 shares.
// Latency 2, one result/cycle; holds up to 2 results under backpressure. MASKED_COMPRESS_DBG_UNMASK_EN adds a debug unmask port.
module masked_gf16_mult_compress #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9*W-1:0]   p_in,
  input  logic [3*W-1:0]   r_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3*W-1:0]   y_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rand_cnt
`ifdef MASKED_COMPRESS_DBG_UNMASK_EN
  ,
  output logic [W-1:0]     dbg_unmasked
`endif
);

  if (W != 4) begin : g_w_check
    $error("masked_gf16_mult_compress: W must be 4");
  end

  logic [8:0][W-1:0] p_arr;
  logic [2:0][W-1:0] r_arr;
  logic [8:0][W-1:0] q_nxt;
  logic [8:0][W-1:0] q_dat;
  logic [2:0][W-1:0] y_nxt;
  logic [2:0][W-1:0] y_dat;
  logic              s1_vld;
  logic              s2_vld;
  logic              accept;
  logic              s2_load;

  assign p_arr = p_in;
  assign r_arr = r_in;

  assign s2_load   = s1_vld & (~s2_vld | out_ready);
  assign in_ready  = ~s1_vld | s2_load;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_vld;
  assign y_out     = y_dat;

  // Every r_k lands in two different output rows, so it cancels in the unmasked sum.
  always_comb begin
    q_nxt    = p_arr;
    q_nxt[1] = p_arr[1] ^ r_arr[0];
    q_nxt[2] = p_arr[2] ^ r_arr[1];
    q_nxt[3] = p_arr[3] ^ r_arr[1];
    q_nxt[5] = p_arr[5] ^ r_arr[2];
    q_nxt[6] = p_arr[6] ^ r_arr[2];
    q_nxt[7] = p_arr[7] ^ r_arr[0];
  end

  // Compression reads only registered q, keeping the glitch barrier intact.
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      y_nxt[i] = q_dat[3*i] ^ q_dat[3*i+1] ^ q_dat[3*i+2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      q_dat  <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      q_dat  <= q_nxt;
    end else if (s2_load) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      y_dat  <= '0;
    end else if (s2_load) begin
      s2_vld <= 1'b1;
      y_dat  <= y_nxt;
    end else if (out_ready) begin
      s2_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rand_cnt <= '0;
    end else if (accept && (rand_cnt != {CNT_W{1'b1}})) begin
      rand_cnt <= rand_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef MASKED_COMPRESS_DBG_UNMASK_EN
  logic [W-1:0] p_sum;
  logic [W-1:0] sh1_sum;

  always_comb begin
    p_sum = '0;
    for (int k = 0; k < 9; k++) begin
      p_sum = p_sum ^ p_arr[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh1_sum <= '0;
    end else if (accept) begin
      sh1_sum <= p_sum;
    end
  end

  assign dbg_unmasked = y_dat[0] ^ y_dat[1] ^ y_dat[2];

  always @(posedge clk) begin
    if (!rst && s2_load) begin
      assert ((y_nxt[0] ^ y_nxt[1] ^ y_nxt[2]) == sh1_sum);
    end
  end
`endif

endmodule

// File: tb/tb_masked_gf16_mult_compress.sv
// Randomized bench for masked_gf16_mult_compress against a share-formula reference model (CNT_W=4 build).
module tb_masked_gf16_mult_compress;

  logic        clk;
  logic        rst;
  logic [35:0] p_in;
  logic [11:0] r_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] y_out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  rand_cnt;
`ifdef MASKED_COMPRESS_DBG_UNMASK_EN
  logic [3:0]  dbg_unmasked;
`endif

  masked_gf16_mult_compress #(.W(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_in      (p_in),
    .r_in      (r_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rand_cnt  (rand_cnt)
`ifdef MASKED_COMPRESS_DBG_UNMASK_EN
    ,
    .dbg_unmasked (dbg_unmasked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          exp_cnt  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  // Output shares straight from the share equations.
  function automatic logic [11:0] model_y(input logic [35:0] p, input logic [11:0] r);
    logic [3:0] pp[3][3];
    logic [3:0] y0, y1, y2;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        pp[i][j] = p[(3*i+j)*4 +: 4];
    y0 = pp[0][0] ^ pp[0][1] ^ pp[0][2] ^ r[3:0] ^ r[7:4];
    y1 = pp[1][0] ^ pp[1][1] ^ pp[1][2] ^ r[7:4] ^ r[11:8];
    y2 = pp[2][0] ^ pp[2][1] ^ pp[2][2] ^ r[11:8] ^ r[3:0];
    return {y2, y1, y0};
  endfunction

  function automatic logic [35:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  function automatic logic [11:0] rand12();
    logic [31:0] u;
    u = $urandom();
    return u[11:0];
  endfunction

  // One clock: drive at posedge+1, observe handshakes at negedge, return at next posedge+1.
  task automatic cyc(input logic vld, input logic [35:0] p, input logic [11:0] r, input logic ordy);
    in_valid  = vld;
    p_in      = p;
    r_in      = r;
    out_ready = ordy;
    #4;
    if (in_valid && in_ready) begin
      exp_q.push_back(model_y(p, r));
      if (exp_cnt < 15) exp_cnt++;
    end
    if (out_valid && out_ready) obs_q.push_back(y_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else pass_cnt++;
    chk_cnt++;
    if (y_out !== 12'h000) $display("FAIL reset_y_out got=%h want=000", y_out); else pass_cnt++;
    chk_cnt++;
    if (rand_cnt !== 4'h0) $display("FAIL reset_rand_cnt got=%h want=0", rand_cnt); else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] xs;
    cyc(1'b1, 36'h3, 12'hFA5, 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_early_valid got=%b want=0", out_valid); else pass_cnt++;
    cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL single_latency_valid got=%b want=1", out_valid); else pass_cnt++;
    chk_cnt++;
    if (y_out !== 12'hA5C) $display("FAIL single_y got=%h want=A5C", y_out); else pass_cnt++;
    xs = y_out[3:0] ^ y_out[7:4] ^ y_out[11:8];
    chk_cnt++;
    if (xs !== 4'h3) $display("FAIL single_unmask got=%h want=3", xs); else pass_cnt++;
    cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (rand_cnt !== 4'(exp_cnt)) $display("FAIL single_rand_cnt got=%0d want=%0d", rand_cnt, exp_cnt); else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_all_f();
    logic [3:0] xs;
    cyc(1'b1, 36'hFFFFFFFFF, 12'h000, 1'b1);
    cyc(1'b1, 36'hFFFFFFFFF, 12'h421, 1'b1);
    cyc(1'b0, rand36(), rand12(), 1'b1);
    cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (obs_q.size() != 2) $display("FAIL allf_count got=%0d want=2", obs_q.size()); else pass_cnt++;
    if (obs_q.size() == 2) begin
      chk_cnt++;
      if (obs_q[0] !== 12'hFFF) $display("FAIL allf_r0 got=%h want=FFF", obs_q[0]); else pass_cnt++;
      chk_cnt++;
      if (obs_q[1] !== 12'hA9C) $display("FAIL allf_r421 got=%h want=A9C", obs_q[1]); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
        xs = obs_q[i][3:0] ^ obs_q[i][7:4] ^ obs_q[i][11:8];
        chk_cnt++;
        if (xs !== 4'hF) $display("FAIL allf_unmask[%0d] got=%h want=F", i, xs); else pass_cnt++;
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    int rdy_miss;
    int vld_miss;
    start_cnt = exp_cnt;
    rdy_miss  = 0;
    vld_miss  = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8 && in_ready !== 1'b1) rdy_miss++;
      if (k < 8) cyc(1'b1, rand36(), rand12(), 1'b1);
      else       cyc(1'b0, rand36(), rand12(), 1'b1);
      if (out_valid !== ((k >= 1 && k <= 8) ? 1'b1 : 1'b0)) vld_miss++;
    end
    chk_cnt++;
    if (rdy_miss != 0) $display("FAIL b2b_in_ready drops=%0d want=0", rdy_miss); else pass_cnt++;
    chk_cnt++;
    if (vld_miss != 0) $display("FAIL b2b_out_valid_pattern errors=%0d want=0", vld_miss); else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 8) $display("FAIL b2b_count got=%0d want=8", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    chk_cnt++;
    if (int'(rand_cnt) - start_cnt != 8)
      $display("FAIL b2b_rand_cnt_delta got=%0d want=8", int'(rand_cnt) - start_cnt);
    else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stall();
    logic [35:0] pd[3];
    logic [11:0] rd[3];
    int          start_cnt;
    int          hold_err;
    start_cnt = exp_cnt;
    hold_err  = 0;
    for (int i = 0; i < 3; i++) begin
      pd[i] = rand36();
      rd[i] = rand12();
    end
    cyc(1'b1, pd[0], rd[0], 1'b0);
    cyc(1'b1, pd[1], rd[1], 1'b0);
    chk_cnt++;
    if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", in_ready); else pass_cnt++;
    chk_cnt++;
    if (y_out !== model_y(pd[0], rd[0])) $display("FAIL stall_y got=%h want=%h", y_out, model_y(pd[0], rd[0])); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, pd[2], rd[2], 1'b0);
      if (y_out !== model_y(pd[0], rd[0]) || out_valid !== 1'b1 || in_ready !== 1'b0) hold_err++;
    end
    chk_cnt++;
    if (hold_err != 0) $display("FAIL stall_hold errors=%0d want=0", hold_err); else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 2) $display("FAIL stall_accepted got=%0d want=2", exp_q.size()); else pass_cnt++;
    cyc(1'b1, pd[2], rd[2], 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (obs_q.size() != 3) $display("FAIL stall_out_count got=%0d want=3", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== model_y(pd[i], rd[i]))
        $display("FAIL stall_order[%0d] got=%h want=%h", i, obs_q[i], model_y(pd[i], rd[i]));
      else pass_cnt++;
    end
    chk_cnt++;
    if (int'(rand_cnt) - start_cnt != 3)
      $display("FAIL stall_rand_cnt_delta got=%0d want=3", int'(rand_cnt) - start_cnt);
    else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [35:0] pc;
    logic [11:0] rc;
    cyc(1'b1, rand36(), rand12(), 1'b0);
    cyc(1'b1, rand36(), rand12(), 1'b0);
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rstmid_prefill got=%b want=1", out_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", out_valid); else pass_cnt++;
    chk_cnt++;
    if (y_out !== 12'h000) $display("FAIL rstmid_y got=%h want=000", y_out); else pass_cnt++;
    chk_cnt++;
    if (rand_cnt !== 4'h0) $display("FAIL rstmid_rand_cnt got=%h want=0", rand_cnt); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    exp_cnt = 0;
    pc = rand36();
    rc = rand12();
    cyc(1'b1, pc, rc, 1'b1);
    cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (out_valid !== 1'b1 || y_out !== model_y(pc, rc))
      $display("FAIL rstmid_first got=%b/%h want=1/%h", out_valid, y_out, model_y(pc, rc));
    else pass_cnt++;
    cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (rand_cnt !== 4'h1) $display("FAIL rstmid_cnt_after got=%h want=1", rand_cnt); else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturation();
    int cnt_err;
    cnt_err = 0;
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, rand36(), rand12(), 1'b1);
      if (rand_cnt !== 4'(exp_cnt)) cnt_err++;
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, rand36(), rand12(), 1'b1);
    chk_cnt++;
    if (cnt_err != 0) $display("FAIL sat_track errors=%0d want=0", cnt_err); else pass_cnt++;
    chk_cnt++;
    if (rand_cnt !== 4'hF) $display("FAIL sat_hold got=%h want=F", rand_cnt); else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 17) $display("FAIL sat_out_count got=%0d want=17", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL sat_data[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); else pass_cnt++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    p_in      = '0;
    r_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_all_f();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/masked_gf16_mult_compress.md
Name: masked_gf16_mult_compress

Overview:
- Downstream stage of the 3-share (second-order, d+1) GF(16) multiplier array.
- Takes the 9 cross-share partial products p_ij = a_i*b_j, each 4 bits, as produced by nine GF(16) multiplier instances.
- Re-masks the partial products with fresh randomness and registers them (the glitch barrier). It then compresses them to 3 output shares in a second register stage.
- Sits between the tower-field inversion multipliers and the next S-box layer. It uses a valid/ready pipeline.

Parameters:
- W, 4, bit width of one GF(16) element. Fixed at 4; any other value is a synthesis error.
- CNT_W, 16, width of the saturating randomness-consumption counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p_in  in  36  partial products. p_ij occupies bits [(3*i+j)*4 +: 4], for i, j in 0..2.
- r_in  in  12  fresh randomness. r0 = [3:0], r1 = [7:4], r2 = [11:8]. Sampled only on input acceptance.
- in_valid  in  1  p_in and r_in are valid.
- in_ready  out  1  stage 1 can accept.
- y_out  out  12  output shares. y0 = [3:0], y1 = [7:4], y2 = [11:8].
- out_valid  out  1  y_out is valid.
- out_ready  in  1  consumer accepts y_out.
- rand_cnt  out  CNT_W  number of accepted inputs, i.e. 12-bit randomness words consumed. Saturates at all-ones.

Behaviour:
- Reset (async, rst=1):
  - s1_valid = 0, s2_valid = 0.
  - All q registers = 0, y_out = 0, rand_cnt = 0.
  - in_ready = 1 is driven combinationally after reset.
- Stage 1 (re-mask register), loaded on accept = in_valid & in_ready:
  - q00 = p00; q01 = p01^r0; q02 = p02^r1.
  - q10 = p10^r1; q11 = p11; q12 = p12^r2.
  - q20 = p20^r2; q21 = p21^r0; q22 = p22.
  - Each r_k appears exactly twice, so the XOR of all q equals the XOR of all p.
- Stage 2 (compression register), loaded on s1 advance:
  - y_i = q_i0 ^ q_i1 ^ q_i2.
  - Resulting shares: y0 = p00^p01^p02^r0^r1; y1 = p10^p11^p12^r1^r2; y2 = p20^p21^p22^r2^r0.
- No combinational path from p_in or r_in to y_out. Compression uses only registered q values.
- Handshake:
  - s2_load = s1_valid & (~s2_valid | out_ready).
  - in_ready = ~s1_valid | s2_load.
  - out_valid = s2_valid.
  - If s1_valid=0 while out_ready=1 and s2_valid=1, s2_valid clears.
- Latency: accept at edge N → out_valid at edge N+2 when out_ready is held high.
- Throughput: one result per cycle when out_ready=1.
- Stall: with out_ready=0, y_out, out_valid, q and s1_valid hold stable. At most 2 results are buffered; then in_ready=0.
- Simultaneous accept and s2_load: stage 1 takes the new data while stage 2 takes the old stage-1 data in the same cycle.
- r_in is ignored (not sampled, no counter change) when no accept occurs. Randomness must be fresh per accept; the block does not check this.
- rand_cnt increments by 1 on each accept. Holds at 2^CNT_W-1 and never wraps.
- Reset mid-operation: in-flight data is discarded; out_valid drops immediately (async).
- No output is X after reset, independent of inputs.

Optional Feature:
- Macro: MASKED_COMPRESS_DBG_UNMASK_EN.
- Defined:
  - Adds port dbg_unmasked, out, 4 bits, = y0^y1^y2 computed from the stage-2 registers.
  - Adds a simulation assertion: on each s2_load, the new XOR sum equals the XOR of the nine p_ij accepted two stages earlier. The p_ij are tracked in a shadow pipeline.
  - For simulation and verification only. Must never be defined in side-channel-evaluated netlists.
- Undefined: no port, no shadow logic, no assertion. Identical area to the base design.

Test Plan:
1. Reset, then p00=4'h3, all other p_ij=0, r=(r0=5, r1=A, r2=F), in_valid pulse, out_ready=1 → out_valid at edge N+2 with y0=4'hC, y1=4'h5, y2=4'hA. XOR of shares = 4'h3.
2. All p_ij=4'hF, r=0 → y0=y1=y2=4'hF. Then all p_ij=4'hF with r=(1,2,4) → y0=4'hC, y1=4'h9, y2=4'hA. XOR of shares = 4'hF in both cases.
3. Back-to-back streaming: 8 inputs, out_ready=1 → 8 outputs on consecutive cycles in order, in_ready stays 1, rand_cnt=8.
4. out_ready=0 with 3 inputs offered → only 2 accepted, then in_ready=0. y_out stays stable. On releasing out_ready, the 3 outputs appear in order and rand_cnt=3.
5. Assert rst while s1 and s2 are both valid → out_valid=0 immediately, y_out=0, rand_cnt=0. After release, first accept yields correct result at N+2.
6. Force rand_cnt near saturation (CNT_W=4 build, 17 accepts) → rand_cnt=4'hF and holds, no wrap.
